// File: rtl/ula_issue_ctrl_if.sv
// Decode/ULA-facing signal bundle for ula_issue_ctrl.
// master = the issue controller, slave = decode stage plus ULA stub.
interface ula_issue_ctrl_if #(
  parameter int unsigned DATA_W = 16
);
  logic              InstrValid;
  logic [15:0]       Instr;
  logic              InstrReady;
  logic              Stall;
  logic [3:0]        CodeULA;
  logic              ExValid;
  logic [2:0]        FlagReg;
  logic [DATA_W-1:0] Res;
  logic [2:0]        FlagQ;
  logic              BranchTaken;
  logic [DATA_W-1:0] BranchTarget;
  logic              Flush;
  logic              IllegalOp;

  modport master (
    input  InstrValid, Instr, Stall, FlagReg, Res,
    output InstrReady, CodeULA, ExValid, FlagQ, BranchTaken, BranchTarget, Flush, IllegalOp
  );

  modport slave (
    output InstrValid, Instr, Stall, FlagReg, Res,
    input  InstrReady, CodeULA, ExValid, FlagQ, BranchTaken, BranchTarget, Flush, IllegalOp
  );
endinterface

// File: rtl/ula_issue_ctrl.sv
// Issue/control end of the ULA: registers CodeULA, captures flags, resolves BEZ.
// Optional illegal-opcode trap (HALT until reset) enabled by ULA_ILLEGAL_TRAP_EN.
//
// state    | meaning
// ST_RUN   | normal issue; acceptance gated by Stall, BEZ and trap in EX
// ST_FLUSH | taken BEZ; Flush high, no acceptance for FLUSH_CYCLES cycles
// ST_HALT  | illegal opcode trapped; only RST leaves
module ula_issue_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned DATA_W       = 16
) (
  input logic             CLK,
  input logic             RST,
  ula_issue_ctrl_if.master bus
);

  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_BEZ = 4'b0110;
  localparam logic [3:0] OP_NOP = 4'b0111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        code_q, code_d;
  logic              exvalid_q, exvalid_d;
  logic [2:0]        flag_q, flag_d;
  logic              taken_q, taken_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [2:0]        fcnt_q, fcnt_d;
  logic              illegal_q, illegal_d;
  logic              trap_ex_q, trap_ex_d;

  logic bez_in_ex;
  logic ready;
  logic accept;
  logic unused_operand;

  assign unused_operand = &{1'b0, bus.Instr[11:0]};

  // Nothing may issue behind a BEZ or a trapping NOP still in EX.
  assign bez_in_ex = exvalid_q && (code_q == OP_BEZ);
  assign ready     = (state_q == ST_RUN) && !bus.Stall && !bez_in_ex && !trap_ex_q;
  assign accept    = bus.InstrValid && ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_RUN;
      code_q    <= OP_NOP;
      exvalid_q <= 1'b0;
      flag_q    <= 3'b100;
      taken_q   <= 1'b0;
      target_q  <= '0;
      fcnt_q    <= 3'd0;
      illegal_q <= 1'b0;
      trap_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      exvalid_q <= exvalid_d;
      flag_q    <= flag_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      fcnt_q    <= fcnt_d;
      illegal_q <= illegal_d;
      trap_ex_q <= trap_ex_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = OP_NOP;
    exvalid_d = 1'b0;
    flag_d    = flag_q;
    taken_d   = 1'b0;
    target_d  = target_q;
    fcnt_d    = fcnt_q;
    illegal_d = illegal_q;
    trap_ex_d = 1'b0;

    // Only the arithmetic/logic ops update status; BEZ and NOP leave it alone.
    if (exvalid_q && (code_q <= OP_XOR)) begin
      flag_d = bus.FlagReg;
    end

    if (accept) begin
      exvalid_d = 1'b1;
      if (bus.Instr[15]) begin
        code_d = OP_NOP;
`ifdef ULA_ILLEGAL_TRAP_EN
        trap_ex_d = 1'b1;
`endif
      end else begin
        code_d = bus.Instr[15:12];
      end
    end

    case (state_q)
      ST_RUN: begin
        if (bez_in_ex && bus.FlagReg[2]) begin
          taken_d  = 1'b1;
          target_d = bus.Res;
          fcnt_d   = 3'(FLUSH_CYCLES - 1);
          state_d  = ST_FLUSH;
        end else if (trap_ex_q) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == 3'd0) begin
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign bus.InstrReady   = ready;
  assign bus.CodeULA      = code_q;
  assign bus.ExValid      = exvalid_q;
  assign bus.FlagQ        = flag_q;
  assign bus.BranchTaken  = taken_q;
  assign bus.BranchTarget = target_q;
  assign bus.Flush        = (state_q == ST_FLUSH);
  assign bus.IllegalOp    = illegal_q;

endmodule

// File: tb/tb_ula_issue_ctrl.sv
// Directed plus randomized bench for ula_issue_ctrl against a cycle-level reference model.
module tb_ula_issue_ctrl;
  localparam int FC = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  ula_issue_ctrl_if #(.DATA_W(16)) bif ();

  ula_issue_ctrl #(.FLUSH_CYCLES(FC), .DATA_W(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bif.master)
  );

  int n_cmp = 0;
  int n_err = 0;
  int lowrun = 0;
  int flushrun = 0;

  logic [3:0]  m_code;
  bit          m_exv;
  logic [2:0]  m_flagq;
  bit          m_taken;
  logic [15:0] m_target;
  int          m_flush_left;
  bit          m_trap;
  bit          m_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_code = 4'd7; m_exv = 0; m_flagq = 3'b100; m_taken = 0; m_target = 16'h0;
    m_flush_left = 0; m_trap = 0; m_halt = 0;
  endtask

  task automatic do_reset();
    bif.InstrValid = 0; bif.Instr = 16'h0; bif.Stall = 0; bif.FlagReg = 3'b000; bif.Res = 16'h0;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs, check all outputs against the model, advance the model.
  task automatic cycle(input bit v, input logic [15:0] ins, input bit st,
                       input logic [2:0] fr, input logic [15:0] res);
    bit rdy_e, acc;
    bif.InstrValid = v; bif.Instr = ins; bif.Stall = st; bif.FlagReg = fr; bif.Res = res;
    #1;
    rdy_e = (m_flush_left == 0) && !m_halt && !m_trap && !st && !(m_exv && m_code == 4'd6);
    chk("CodeULA", bif.CodeULA, m_code);
    chk("ExValid", bif.ExValid, m_exv);
    chk("FlagQ", bif.FlagQ, m_flagq);
    chk("BranchTaken", bif.BranchTaken, m_taken);
    chk("BranchTarget", bif.BranchTarget, m_target);
    chk("Flush", bif.Flush, m_flush_left > 0);
    chk("IllegalOp", bif.IllegalOp, m_halt);
    chk("InstrReady", bif.InstrReady, rdy_e);
    if (bif.InstrReady === 1'b0) lowrun++;
    if (bif.Flush === 1'b1) flushrun++;

    acc = v && rdy_e;
    if (m_exv && m_code < 4'd6) m_flagq = fr;
    if (m_exv && m_code == 4'd6 && fr[2]) begin
      m_taken = 1; m_target = res; m_flush_left = FC;
    end else begin
      m_taken = 0;
      if (m_flush_left > 0) m_flush_left--;
    end
    if (m_trap) m_halt = 1;
    m_trap = 0;
    m_exv = acc;
    m_code = 4'd7;
    if (acc) begin
      if (ins[15]) begin
`ifdef ULA_ILLEGAL_TRAP_EN
        m_trap = 1;
`endif
      end else begin
        m_code = ins[15:12];
      end
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [3:0] op;
    model_reset();
    do_reset();
    chk("rst_code", bif.CodeULA, 4'b0111);
    chk("rst_exv", bif.ExValid, 1'b0);
    chk("rst_flagq", bif.FlagQ, 3'b100);
    chk("rst_flush", bif.Flush, 1'b0);
    chk("rst_target", bif.BranchTarget, 16'h0);

    // ADD then flag capture
    cycle(1, 16'h0123, 0, 3'b000, 16'h0);
    chk("add_code", bif.CodeULA, 4'b0000);
    chk("add_exv", bif.ExValid, 1'b1);
    cycle(0, 16'h0, 0, 3'b010, 16'h1111);
    chk("add_flagq", bif.FlagQ, 3'b010);

    // taken BEZ; SUB offered throughout must wait
    cycle(1, 16'h6000, 0, 3'b000, 16'h0);
    lowrun = 0; flushrun = 0;
    cycle(1, 16'h1000, 0, 3'b100, 16'h0040);
    chk("bez_taken", bif.BranchTaken, 1'b1);
    chk("bez_target", bif.BranchTarget, 16'h0040);
    chk("bez_flagq", bif.FlagQ, 3'b010);
    cycle(1, 16'h1000, 0, 3'b000, 16'h0);
    chk("bez_pulse_one", bif.BranchTaken, 1'b0);
    cycle(1, 16'h1000, 0, 3'b000, 16'h0);
    chk("bez_rdy_low_run", lowrun, 3);
    chk("bez_flush_run", flushrun, FC);
    cycle(1, 16'h1000, 0, 3'b000, 16'h0);
    chk("post_flush_code", bif.CodeULA, 4'b0001);

    // not-taken BEZ with N/V set
    cycle(1, 16'h6000, 0, 3'b001, 16'h0);
    lowrun = 0;
    cycle(1, 16'h3000, 0, 3'b011, 16'h0);
    chk("nt_taken", bif.BranchTaken, 1'b0);
    chk("nt_flagq", bif.FlagQ, 3'b001);
    cycle(1, 16'h3000, 0, 3'b000, 16'h0);
    chk("nt_rdy_low_run", lowrun, 1);
    chk("nt_code", bif.CodeULA, 4'b0011);

    // stall
    cycle(1, 16'h4000, 1, 3'b110, 16'h0);
    cycle(1, 16'h4000, 1, 3'b111, 16'h0);
    cycle(1, 16'h4000, 1, 3'b111, 16'h0);
    chk("stall_code", bif.CodeULA, 4'b0111);
    chk("stall_flagq", bif.FlagQ, 3'b110);
    cycle(1, 16'h4000, 0, 3'b000, 16'h0);
    chk("unstall_code", bif.CodeULA, 4'b0100);

    // reset during first flush cycle
    cycle(1, 16'h6000, 0, 3'b000, 16'h0);
    cycle(0, 16'h0, 0, 3'b100, 16'hBEEF);
    chk("mid_flush", bif.Flush, 1'b1);
    do_reset();
    chk("rf_flush", bif.Flush, 1'b0);
    chk("rf_taken", bif.BranchTaken, 1'b0);
    chk("rf_flagq", bif.FlagQ, 3'b100);
    chk("rf_ready", bif.InstrReady, 1'b1);

    // illegal opcode
    cycle(1, 16'hA000, 0, 3'b000, 16'h0);
    chk("ill_code", bif.CodeULA, 4'b0111);
    chk("ill_exv", bif.ExValid, 1'b1);
`ifdef ULA_ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) cycle(1, 16'h0000, 0, 3'b011, 16'h0);
    chk("ill_sticky", bif.IllegalOp, 1'b1);
    chk("ill_halt_exv", bif.ExValid, 1'b0);
    do_reset();
    chk("ill_cleared", bif.IllegalOp, 1'b0);
`else
    cycle(1, 16'h0000, 0, 3'b011, 16'h0);
    chk("ill_continue", bif.CodeULA, 4'b0000);
    chk("ill_flagq", bif.FlagQ, 3'b100);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
`ifdef ULA_ILLEGAL_TRAP_EN
        op = 4'($urandom_range(0, 7));
`else
        op = 4'($urandom_range(0, 15));
`endif
        if ($urandom_range(0, 3) == 0) op = 4'd6;
        cycle($urandom_range(0, 9) < 7, {op, 12'($urandom)}, $urandom_range(0, 3) == 0,
              3'($urandom), 16'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
